// File: rtl/clic_reg_arbiter_pkg.sv
// Shared types and helpers for the CLIC register-bus arbiter.
package clic_reg_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clic_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index strictly after last_i, wrapping.
module clic_rr_pick
  import clic_reg_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]            valid_i,
  input  logic [idx_width(N)-1:0] last_i,
  output logic                    found_o,
  output logic [idx_width(N)-1:0] idx_o
);

  localparam int IW = idx_width(N);

  logic [IW-1:0] cand_s;

  // Search last+1, last+2, ... mod N; the earliest hit keeps priority.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand_s  = '0;
    for (int i = 1; i <= N; i++) begin
      cand_s = IW'((int'(last_i) + i) % N);
      if (!found_o && valid_i[cand_s]) begin
        found_o = 1'b1;
        idx_o   = cand_s;
      end else begin
        found_o = found_o;
      end
    end
  end

endmodule

// File: rtl/clic_reg_arbiter.sv
// Round-robin arbiter sharing one CLIC register-bus slave port between N_REQ
// requesters, one transaction in flight, with a per-transaction timeout.
module clic_reg_arbiter
  import clic_reg_arb_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [N_REQ-1:0]             req_valid_i,
  input  logic [N_REQ-1:0]             req_write_i,
  input  logic [N_REQ*ADDR_WIDTH-1:0]  req_addr_i,
  input  logic [N_REQ*DATA_WIDTH-1:0]  req_wdata_i,
  input  logic [N_REQ*DATA_WIDTH/8-1:0] req_wstrb_i,
  output logic [N_REQ-1:0]             req_ready_o,
  output logic [DATA_WIDTH-1:0]        req_rdata_o,
  output logic                         req_error_o,
  output logic                         mst_valid_o,
  output logic                         mst_write_o,
  output logic [ADDR_WIDTH-1:0]        mst_addr_o,
  output logic [DATA_WIDTH-1:0]        mst_wdata_o,
  output logic [DATA_WIDTH/8-1:0]      mst_wstrb_o,
  input  logic                         mst_ready_i,
  input  logic [DATA_WIDTH-1:0]        mst_rdata_i,
  input  logic                         mst_error_i
);

  localparam int IW = idx_width(N_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = DATA_WIDTH / 8;
  localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);

  state_e          state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   last_q, last_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            pick_found_s;
  logic [IW-1:0]   pick_idx_s;
  logic            sel_valid_s;
  logic            sel_write_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;
  logic [SW-1:0]   sel_wstrb_s;

  clic_rr_pick #(.N(N_REQ)) u_pick (
    .valid_i (req_valid_i),
    .last_i  (last_q),
    .found_o (pick_found_s),
    .idx_o   (pick_idx_s)
  );

  always_comb begin
    sel_valid_s = req_valid_i[grant_q];
    sel_write_s = req_write_i[grant_q];
    sel_addr_s  = req_addr_i[int'(grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
    sel_wdata_s = req_wdata_i[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    sel_wstrb_s = req_wstrb_i[int'(grant_q)*SW +: SW];
  end

  // A granted requester withdrawing valid aborts silently; ready beats a simultaneous timeout.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    tmo_d       = tmo_q;
    mst_valid_o = 1'b0;
    mst_write_o = 1'b0;
    mst_addr_o  = '0;
    mst_wdata_o = '0;
    mst_wstrb_o = '0;
    req_ready_o = '0;
    req_rdata_o = '0;
    req_error_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found_s) begin
          grant_d = pick_idx_s;
          tmo_d   = '0;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (!sel_valid_s) begin
          state_d = IDLE;
        end else begin
          mst_valid_o = 1'b1;
          mst_write_o = sel_write_s;
          mst_addr_o  = sel_addr_s;
          mst_wdata_o = sel_wdata_s;
          mst_wstrb_o = sel_wstrb_s;
          if (mst_ready_i) begin
            req_ready_o[grant_q] = 1'b1;
            req_rdata_o          = mst_rdata_i;
            req_error_o          = mst_error_i;
            last_d               = grant_q;
            state_d              = IDLE;
          end else if (tmo_q == TMO_LAST) begin
            req_ready_o[grant_q] = 1'b1;
            req_error_o          = 1'b1;
            last_d               = grant_q;
            state_d              = IDLE;
          end else if (tmo_q != TMO_MAX) begin
            tmo_d = tmo_q + TW'(1);
          end else begin
            tmo_d = tmo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule
